// File: rtl/hpm_counter_bank_if.sv
// hpm_bus_if: SRAM-like single-cycle access port of the performance-monitor bank.
//   addr  : {space[1:0], idx}, driven by the master (CSR file)
//   we    : write enable, driven by the master
//   wdata : 64-bit write data, driven by the master
//   rdata : 64-bit read data, combinational from the bank's current state
interface hpm_bus_if #(
  parameter int ADDR_W = 5
) ();
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [63:0]       wdata;
  logic [63:0]       rdata;

  modport master (output addr, we, wdata, input rdata);
  modport slave  (input addr, we, wdata, output rdata);
endinterface

// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank: bank of NUM_CNT programmable performance counters.
// Each counter selects one of NUM_EVT event lines and adds that line's
// 0..MAX_INC increment every cycle it is active, wrapping modulo 2^CNT_W and
// setting a sticky overflow flag on carry-out. Overflows of counters with
// irq_en set raise a registered, level-sensitive interrupt.
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset, clears all state
//   debug_mode_i freezes all counting while high
//   bus          access port (slave side): addr {space, idx}, we, wdata, rdata
//   evt_inc_i    packed per-event increments, INC_W bits per event; event 0 unused
//   ovf_vec_o    sticky overflow flags, one per counter
//   irq_o        overflow interrupt
module hpm_counter_bank #(
  parameter int  NUM_CNT = 8,
  parameter int  CNT_W   = 64,
  parameter int  NUM_EVT = 16,
  parameter int  MAX_INC = 2,
  localparam int IDX_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1,
  localparam int INC_W   = $clog2(MAX_INC + 1),
  localparam int SEL_W   = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     debug_mode_i,
  hpm_bus_if.slave                 bus,
  input  logic [NUM_EVT*INC_W-1:0] evt_inc_i,
  output logic [NUM_CNT-1:0]       ovf_vec_o,
  output logic                     irq_o
);

  localparam logic [1:0] SP_CNT  = 2'd0;
  localparam logic [1:0] SP_SEL  = 2'd1;
  localparam logic [1:0] SP_CTRL = 2'd2;
  localparam logic [1:0] SP_GLB  = 2'd3;

  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d [NUM_CNT];
  logic [SEL_W-1:0]   sel_q [NUM_CNT];
  logic [SEL_W-1:0]   sel_d [NUM_CNT];
  logic [NUM_CNT-1:0] inh_q, inh_d;
  logic [NUM_CNT-1:0] irq_en_q, irq_en_d;
  logic [NUM_CNT-1:0] ovf_q, ovf_d;
  logic               irq_q, irq_d;

  logic [INC_W-1:0]   evt_inc [NUM_EVT];
  logic [1:0]         space;
  logic [IDX_W-1:0]   idx;
  logic [63:0]        rdata;

  assign space = bus.addr[IDX_W+1:IDX_W];
  assign idx   = bus.addr[IDX_W-1:0];

  always_comb begin
    for (int e = 0; e < NUM_EVT; e++) begin
      evt_inc[e] = evt_inc_i[e*INC_W +: INC_W];
    end
  end

  // Next-state: increment, then software writes override per field.
  always_comb begin
    logic             act;
    logic [INC_W-1:0] inc;
    logic [CNT_W:0]   sum;
    logic             hit;
    logic             ovf_set;
    logic             ovf_clr;
    act     = 1'b0;
    inc     = '0;
    sum     = '0;
    hit     = 1'b0;
    ovf_set = 1'b0;
    ovf_clr = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      // sel 0 means "no event"; sel values beyond the event map are stored but count nothing.
      act = !debug_mode_i && !inh_q[i] && (sel_q[i] != '0) && (int'(sel_q[i]) < NUM_EVT);
      inc = act ? evt_inc[sel_q[i]] : '0;
      sum = {1'b0, cnt_q[i]} + (CNT_W+1)'(inc);
      hit = bus.we && (idx == IDX_W'(i));

      cnt_d[i]    = sum[CNT_W-1:0];
      sel_d[i]    = sel_q[i];
      inh_d[i]    = inh_q[i];
      irq_en_d[i] = irq_en_q[i];
      ovf_set     = sum[CNT_W];
      ovf_clr     = 1'b0;

      if (hit) begin
        case (space)
          SP_CNT: begin
            // The discarded sum must not leave an overflow behind.
            cnt_d[i] = bus.wdata[CNT_W-1:0];
            ovf_set  = 1'b0;
          end
          SP_SEL:  sel_d[i] = bus.wdata[SEL_W-1:0];
          SP_CTRL: begin
            inh_d[i]    = bus.wdata[0];
            irq_en_d[i] = bus.wdata[1];
            ovf_clr     = bus.wdata[2];
          end
          default: ;
        endcase
      end
      if (bus.we && (space == SP_GLB) && (idx == '0)) begin
        ovf_clr = ovf_clr | bus.wdata[i];
      end

      // A fresh overflow wins over a same-cycle clear.
      ovf_d[i] = ovf_set | (ovf_q[i] & ~ovf_clr);
    end
    irq_d = |(ovf_d & irq_en_d);
  end

  // Read mux: reflects the pre-write state of the current cycle.
  always_comb begin
    rdata = '0;
    if (space == SP_GLB) begin
      if (idx == '0) rdata[NUM_CNT-1:0] = ovf_q;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (idx == IDX_W'(i)) begin
          case (space)
            SP_CNT:  rdata[CNT_W-1:0] = cnt_q[i];
            SP_SEL:  rdata[SEL_W-1:0] = sel_q[i];
            SP_CTRL: rdata[2:0]       = {ovf_q[i], irq_en_q[i], inh_q[i]};
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= '0;
        sel_q[i] <= '0;
      end
      inh_q    <= '0;
      irq_en_q <= '0;
      ovf_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= cnt_d[i];
        sel_q[i] <= sel_d[i];
      end
      inh_q    <= inh_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.rdata = rdata;
  assign ovf_vec_o = ovf_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Testbench for hpm_counter_bank: directed stimulus, a cycle-level reference
// model of the counter bank and a per-cycle output compare.
module tb_hpm_counter_bank;
  localparam int NUM_CNT = 5;
  localparam int CNT_W   = 8;
  localparam int NUM_EVT = 12;
  localparam int MAX_INC = 3;
  localparam int INC_W   = 2;
  localparam int ADDR_W  = 5;
  localparam int MODULUS = 1 << CNT_W;
  localparam int SP_CNT = 0, SP_SEL = 1, SP_CTRL = 2, SP_GLB = 3;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  logic dbg    = 1'b0;
  logic [NUM_EVT*INC_W-1:0] evt_vec;
  logic [NUM_CNT-1:0]       ovf_vec;
  logic                     irq;
  int ev [NUM_EVT];

  int  tests  = 0;
  int  fails  = 0;
  bit  cmp_en = 1'b0;

  // Reference model state
  int m_cnt [NUM_CNT];
  int m_sel [NUM_CNT];
  bit m_inh [NUM_CNT];
  bit m_ien [NUM_CNT];
  bit m_ovf [NUM_CNT];
  bit m_irq;

  hpm_bus_if #(.ADDR_W(ADDR_W)) bus ();

  hpm_counter_bank #(
    .NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .NUM_EVT(NUM_EVT), .MAX_INC(MAX_INC)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .debug_mode_i (dbg),
    .bus          (bus),
    .evt_inc_i    (evt_vec),
    .ovf_vec_o    (ovf_vec),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  always_comb begin
    evt_vec = '0;
    for (int e = 0; e < NUM_EVT; e++) evt_vec[e*INC_W +: INC_W] = INC_W'(ev[e]);
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endfunction

  function automatic logic [63:0] model_ovf();
    logic [63:0] r = '0;
    for (int i = 0; i < NUM_CNT; i++) r[i] = m_ovf[i];
    return r;
  endfunction

  function automatic logic [63:0] model_read();
    int sp = int'(bus.addr) >> 3;
    int ix = int'(bus.addr) & 7;
    logic [63:0] r = '0;
    if (sp == SP_GLB) begin
      if (ix == 0) r = model_ovf();
    end else if (ix < NUM_CNT) begin
      case (sp)
        SP_CNT:  r = 64'(m_cnt[ix]);
        SP_SEL:  r = 64'(m_sel[ix]);
        SP_CTRL: r = 64'(m_ovf[ix] * 4 + m_ien[ix] * 2 + m_inh[ix]);
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // One clock of the bank's behaviour, from the inputs present this cycle.
  function automatic void model_step();
    int sp = int'(bus.addr) >> 3;
    int ix = int'(bus.addr) & 7;
    bit any_irq = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      int inc = 0;
      int sum;
      bit hit = bus.we && (ix == i);
      bit set = 1'b0;
      bit clr = 1'b0;
      if (!dbg && !m_inh[i] && m_sel[i] > 0 && m_sel[i] < NUM_EVT) inc = ev[m_sel[i]];
      sum = m_cnt[i] + inc;
      if (hit && sp == SP_CNT) begin
        m_cnt[i] = int'(bus.wdata[7:0]);
      end else begin
        m_cnt[i] = sum % MODULUS;
        set = (sum >= MODULUS);
      end
      if (hit && sp == SP_CTRL && bus.wdata[2]) clr = 1'b1;
      if (bus.we && sp == SP_GLB && ix == 0 && bus.wdata[i]) clr = 1'b1;
      m_ovf[i] = set || (m_ovf[i] && !clr);
      if (hit && sp == SP_SEL) m_sel[i] = int'(bus.wdata[3:0]);
      if (hit && sp == SP_CTRL) begin
        m_inh[i] = bus.wdata[0];
        m_ien[i] = bus.wdata[1];
      end
      if (m_ovf[i] && m_ien[i]) any_irq = 1'b1;
    end
    m_irq = any_irq;
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        m_cnt[i] = 0; m_sel[i] = 0; m_inh[i] = 0; m_ien[i] = 0; m_ovf[i] = 0;
      end
      m_irq = 1'b0;
    end else begin
      model_step();
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_data_o", bus.rdata, model_read());
      check("cyc_ovf_vec_o", 64'(ovf_vec), model_ovf());
      check("cyc_irq_o", 64'(irq), 64'(m_irq));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setaddr(int sp, int ix);
    bus.we   = 1'b0;
    bus.addr = ADDR_W'(sp * 8 + ix);
  endtask

  task automatic wr(int sp, int ix, logic [63:0] d);
    bus.addr  = ADDR_W'(sp * 8 + ix);
    bus.wdata = d;
    bus.we    = 1'b1;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic rd(int sp, int ix, logic [63:0] exp, string name);
    setaddr(sp, ix);
    #1;
    check(name, bus.rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.addr  = '0;
    bus.we    = 1'b0;
    bus.wdata = '0;
    for (int e = 0; e < NUM_EVT; e++) ev[e] = 3;

    // Reset with every event line high
    repeat (3) cyc();
    check("rst_data_o", bus.rdata, 64'd0);
    check("rst_ovf", 64'(ovf_vec), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    rst_ni = 1'b1;
    cmp_en = 1'b1;
    repeat (3) cyc();
    for (int i = 0; i < NUM_CNT; i++) rd(SP_CNT, i, 64'd0, "sel0_cnt");
    check("sel0_ovf", 64'(ovf_vec), 64'd0);
    for (int e = 0; e < NUM_EVT; e++) ev[e] = 0;

    // Multi-port counting: +2 for 10 cycles
    wr(SP_SEL, 0, 64'd3);
    setaddr(SP_CNT, 0);
    ev[3] = 2;
    repeat (10) cyc();
    ev[3] = 0;
    check("multiport_cnt0", bus.rdata, 64'd20);

    // Wrap and interrupt
    wr(SP_CTRL, 1, 64'd2);
    wr(SP_SEL, 1, 64'd5);
    wr(SP_CNT, 1, 64'd254);
    setaddr(SP_CNT, 1);
    check("wrap_irq_pre", 64'(irq), 64'd0);
    ev[5] = 3;
    cyc();
    ev[5] = 0;
    check("wrap_cnt1", bus.rdata, 64'd1);
    check("wrap_ovf", 64'(ovf_vec), 64'h2);
    check("wrap_irq", 64'(irq), 64'd1);
    rd(SP_CTRL, 1, 64'd6, "wrap_ctrl_rd");
    wr(SP_CTRL, 1, 64'd6);
    check("w1c_ctrl_ovf", 64'(ovf_vec), 64'd0);
    check("w1c_ctrl_irq", 64'(irq), 64'd0);

    // Write beats increment
    ev[3] = 1;
    wr(SP_CNT, 0, 64'd100);
    ev[3] = 0;
    rd(SP_CNT, 0, 64'd100, "collide_cnt0");

    // Overflow beats same-cycle W1C
    wr(SP_CNT, 1, 64'd255);
    ev[5] = 1;
    wr(SP_GLB, 0, 64'h2);
    ev[5] = 0;
    check("collide_ovf", 64'(ovf_vec), 64'h2);
    check("collide_irq", 64'(irq), 64'd1);
    rd(SP_CNT, 1, 64'd0, "collide_cnt1");
    rd(SP_GLB, 1, 64'd0, "glb_idx1_rd");
    rd(SP_GLB, 0, 64'h2, "glb_rd");
    wr(SP_GLB, 0, 64'h2);
    check("glb_clr_ovf", 64'(ovf_vec), 64'd0);
    check("glb_clr_irq", 64'(irq), 64'd0);

    // Inhibit
    wr(SP_CTRL, 0, 64'd1);
    ev[3] = 2;
    setaddr(SP_CNT, 0);
    repeat (5) cyc();
    check("inh_frozen", bus.rdata, 64'd100);
    wr(SP_CTRL, 0, 64'd0);
    rd(SP_CNT, 0, 64'd100, "inh_release_cycle");
    cyc();
    check("inh_resume", bus.rdata, 64'd102);

    // Debug freeze
    dbg = 1'b1;
    repeat (5) cyc();
    check("dbg_frozen", bus.rdata, 64'd102);
    dbg = 1'b0;
    cyc();
    check("dbg_resume", bus.rdata, 64'd104);
    ev[3] = 0;

    // Map edges: idx beyond the bank
    wr(SP_CNT, 5, 64'd77);
    wr(SP_SEL, 5, 64'd3);
    wr(SP_CTRL, 5, 64'd3);
    rd(SP_CNT, 5, 64'd0, "idx5_cnt");
    rd(SP_SEL, 5, 64'd0, "idx5_sel");
    rd(SP_CTRL, 5, 64'd0, "idx5_ctrl");
    rd(SP_CNT, 7, 64'd0, "idx7_cnt");
    cyc();

    // Map edges: sel beyond the event map
    wr(SP_SEL, 2, 64'd12);
    wr(SP_CNT, 2, 64'd50);
    for (int e = 0; e < NUM_EVT; e++) ev[e] = 3;
    setaddr(SP_CNT, 2);
    repeat (5) cyc();
    check("sel12_frozen", bus.rdata, 64'd50);
    rd(SP_SEL, 2, 64'd12, "sel12_stored");
    for (int e = 0; e < NUM_EVT; e++) ev[e] = 0;
    cyc();

    // Asynchronous reset mid-cycle
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_data", bus.rdata, 64'd0);
    rd(SP_CNT, 0, 64'd0, "async_rst_cnt0");
    rd(SP_SEL, 0, 64'd0, "async_rst_sel0");
    cyc();
    rst_ni = 1'b1;
    repeat (2) cyc();
    rd(SP_CNT, 0, 64'd0, "post_rst_cnt0");
    cyc();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
